uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 16, SHALL set the number of CLK cycles per serial bit (legal range 2..65535).
- REQ-002: Parameter DATA_BITS, default 8, SHALL set the data bits per frame (legal range 5..8).
- REQ-003: Parameter STOP_BITS, default 1, SHALL set the stop bits per frame (legal values 1 or 2).
- REQ-004: Parameter PARITY_ODD, default 1'b0, SHALL select odd parity when 1 and even parity when 0 (used only with UART_TX_PARITY_EN).
- REQ-005: Port CLK, input, width 1, SHALL be the single clock; all logic is on its rising edge.
- REQ-006: Port RST, input, width 1, SHALL be the synchronous, active-high reset.
- REQ-007: Port tx_data, input, width DATA_BITS, SHALL be the byte to send.
- REQ-008: Port tx_valid, input, width 1, SHALL indicate that tx_data is valid.
- REQ-009: Port tx_ready, output, width 1, SHALL indicate that the block can accept a new byte.
- REQ-010: Port tx, output, width 1, SHALL be the serial line; it idles high.
- REQ-011: Port busy, output, width 1, SHALL be high while a frame is on the line.

Function
- REQ-012: The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, and leave each state only when the bit counter expires.
- REQ-013: tx_ready SHALL be high only in IDLE, and busy SHALL equal the inverse of tx_ready.
- REQ-014: A byte is accepted when tx_valid and tx_ready are both high on a rising edge; tx_data is then latched into a shift register.
- REQ-015: After acceptance the state SHALL go to START, so tx drives 0 starting on the next cycle.
- REQ-016: Every bit (start, data, parity, stop) SHALL be held on tx for exactly CLKS_PER_BIT cycles.
- REQ-017: Data bits SHALL be sent LSB first, DATA_BITS in total.
- REQ-018: In STOP, tx SHALL be driven high for STOP_BITS*CLKS_PER_BIT cycles, then the FSM returns to IDLE.
- REQ-019: Changes on tx_data or tx_valid after acceptance SHALL NOT affect the frame in flight.
- REQ-020: With tx_valid held high continuously, frames SHALL be separated by exactly one idle-high cycle (the IDLE acceptance cycle).
- REQ-021: The baud counter SHALL be width $clog2(CLKS_PER_BIT), count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
- REQ-022: tx SHALL be driven from a flop (glitch-free) and SHALL NOT be driven combinationally.

Reset
- REQ-023: When RST is high at a rising edge, on that same edge the FSM SHALL go to IDLE, tx SHALL be 1, tx_ready 1, busy 0, and the counters and shift register 0.
- REQ-024: Reset asserted mid-frame SHALL abort the frame; tx SHALL be high after the edge, and no partial frame resumes.
- REQ-025: A byte presented while RST is high SHALL NOT be accepted.

Configuration
- REQ-026: With UART_TX_PARITY_EN defined, the PARITY state SHALL be entered after DATA.
  - It sends one bit, which is the XOR of the latched data, inverted when PARITY_ODD = 1.
- REQ-027: Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
- REQ-028: A shared package uart_pkg SHALL hold the uart_tx_state_t enum and the default baud/data-width constants.
- REQ-029: Baud timing SHALL be implemented in the sub-module uart_baud_gen, which produces a one-cycle bit_done pulse and has a restart input.

Verification
- REQ-030: Parameters CLKS_PER_BIT=4, no parity; send 0xA5 -> tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; tx_ready returns high 40 cycles after acceptance.
- REQ-031: Same parameters with tx_valid held high and 0x00 then 0xFF queued -> two frames with exactly one idle-high cycle between them; the second is accepted on the IDLE cycle.
- REQ-032: Parameters UART_TX_PARITY_EN defined, PARITY_ODD=0; send 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame length is 44 cycles.
- REQ-033: Assert RST for 1 cycle in the middle of data bit 3 -> tx = 1 and tx_ready = 1 on the next cycle; a new byte 0x3C is then sent correctly.
- REQ-034: Change tx_data from 0x55 to 0xAA in the cycle after acceptance -> the serialized bits match 0x55.
- REQ-035: STOP_BITS=2, CLKS_PER_BIT=4 -> the stop period is 8 high cycles, and tx_ready stays 0 until it ends.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default
// baud/data-width constants. The PARITY state exists only when
// UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEF = 16;
  localparam int unsigned UART_DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1,
// pulses bit_done on the last count and wraps to 0. restart holds the
// counter at 0 so a new frame always starts on a full bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_done = (cnt == CNT_LAST);

  // Free-running bit counter, cleared on reset, restart and bit boundary
  always_ff @(posedge CLK) begin
    if (RST || restart || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, STOP_BITS stop bits. tx is registered.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after
// the data bits (odd when PARITY_ODD = 1, even otherwise).
//
//   state  | meaning
//   IDLE   | line high, tx_ready high, byte accepted on tx_valid
//   START  | start bit (low) on the line
//   DATA   | data bits shifted out LSB first
//   PARITY | parity bit on the line (UART_TX_PARITY_EN only)
//   STOP   | line high for STOP_BITS bit periods
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS_DEF,
  parameter int unsigned STOP_BITS    = 1,
  parameter logic        PARITY_ODD   = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 bit_done;
  logic                 baud_restart;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`else
  // Parity sense has no effect when the parity bit is not built in
  logic                 unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign tx_ready     = (state_q == IDLE);
  assign busy         = ~tx_ready;
  assign tx           = tx_q;
  assign baud_restart = (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .CLK     (CLK),
    .RST     (RST),
    .restart (baud_restart),
    .bit_done(bit_done)
  );

  // Next-state, shift and next line value; tx_d is what the line shows next cycle
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d     = (^tx_data) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = par_q;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, shift register and line flop; reset aborts any frame in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 stop/even parity, 2 stop/odd parity)
// at 4 clocks per bit. Expected per-cycle {tx, tx_ready} pairs are queued
// when a byte is driven and popped one per cycle as the DUT transmits.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LEN1 = CPB * (1 + 8 + PAR_BITS + 1);

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx, busy;
  logic       tx_ready2, tx2, busy2;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];   // {tx, tx_ready} per cycle

  always #5 CLK = ~CLK;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1'b1)) dut2 (
    .CLK(CLK), .RST(RST), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2)
  );

  // Queue the line/ready waveform of one frame plus the following idle cycle
  task automatic push_frame(input logic [7:0] d, input int stop_bits, input logic odd);
    logic seq[$];
    logic par;
    par = (^d) ^ odd;
    seq.push_back(1'b0);
    for (int b = 0; b < 8; b++) seq.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    seq.push_back(par);
`endif
    for (int s = 0; s < stop_bits; s++) seq.push_back(1'b1);
    foreach (seq[k]) for (int c = 0; c < CPB; c++) exp_q.push_back({seq[k], 1'b0});
    exp_q.push_back(2'b11);
  endtask

  task automatic test_reset();
    RST = 1'b1; tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = 8'h00; tx_data2 = 8'h00;
    repeat (3) @(negedge CLK);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx2 !== 1'b1) begin errors++; $display("FAIL reset_tx2: got %b want 1", tx2); end
    checks++; if (tx_ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready2: got %b want 1", tx_ready2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b want 0", busy2); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_frame(input logic [7:0] d, input string name);
    logic [1:0] e;
    int i = 0;
    tx_valid = 1'b1; tx_data = d;
    push_frame(d, 1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      if (i == 0) tx_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({tx, tx_ready} !== e)
        begin errors++; $display("FAIL %s cyc %0d: tx,ready=%b%b want %b", name, i, tx, tx_ready, e); end
      checks++;
      if (busy !== ~e[0])
        begin errors++; $display("FAIL %s_busy cyc %0d: got %b want %b", name, i, busy, ~e[0]); end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    int i = 0;
    tx_valid = 1'b1; tx_data = 8'h00;
    push_frame(8'h00, 1, 1'b0);
    push_frame(8'hFF, 1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      if (i == 0) tx_data = 8'hFF;
      e = exp_q.pop_front();
      checks++;
      if ({tx, tx_ready} !== e)
        begin errors++; $display("FAIL back_to_back cyc %0d: tx,ready=%b%b want %b", i, tx, tx_ready, e); end
      if (i == LEN1 + 1) tx_valid = 1'b0;
      i++;
    end
  endtask

  task automatic test_data_change();
    logic [1:0] e;
    int i = 0;
    tx_valid = 1'b1; tx_data = 8'h55;
    push_frame(8'h55, 1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      if (i == 0) begin tx_valid = 1'b0; tx_data = 8'hAA; end
      if (i == 3) tx_valid = 1'b1;
      if (i == 7) tx_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({tx, tx_ready} !== e)
        begin errors++; $display("FAIL data_change cyc %0d: tx,ready=%b%b want %b", i, tx, tx_ready, e); end
      i++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] e;
    tx_valid = 1'b1; tx_data = 8'hC3;
    push_frame(8'hC3, 1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      if (i == 0) tx_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({tx, tx_ready} !== e)
        begin errors++; $display("FAIL pre_reset cyc %0d: tx,ready=%b%b want %b", i, tx, tx_ready, e); end
    end
    exp_q.delete();
    RST = 1'b1; tx_valid = 1'b1; tx_data = 8'h99;
    @(negedge CLK);
    RST = 1'b0; tx_valid = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++;
      if ({tx, tx_ready} !== 2'b11)
        begin errors++; $display("FAIL post_reset_idle cyc %0d: tx,ready=%b%b want 11", i, tx, tx_ready); end
    end
    test_frame(8'h3C, "after_reset_3c");
  endtask

  task automatic test_stop_bits_odd();
    logic [1:0] e;
    int i = 0;
    tx_valid2 = 1'b1; tx_data2 = 8'h07;
    push_frame(8'h07, 2, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      if (i == 0) tx_valid2 = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({tx2, tx_ready2} !== e)
        begin errors++; $display("FAIL stop2_odd cyc %0d: tx,ready=%b%b want %b", i, tx2, tx_ready2, e); end
      checks++;
      if (busy2 !== ~e[0])
        begin errors++; $display("FAIL stop2_busy cyc %0d: got %b want %b", i, busy2, ~e[0]); end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, "frame_a5");
    test_frame(8'h07, "frame_07_even");
    test_back_to_back();
    test_data_change();
    test_reset_mid_frame();
    test_stop_bits_odd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
